// File: rtl/tqvp_vga_raster.sv
// ============================================================================
// Module   : tqvp_vga_raster
// Brief    : VGA timing and pattern generator with a small register file.
//            Optional raster-line interrupt enabled by macro VGA_RASTER_IRQ_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tqvp_vga_raster #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int COORD_W  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  ui_in,
  output logic [7:0]  uo_out,
  input  logic [5:0]  address,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        user_interrupt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [COORD_W-1:0] X_LAST   = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] Y_LAST   = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] X_VIS    = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] Y_VIS    = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [6:0]         ctrl_q, ctrl_d;
  logic [11:0]        color_q, color_d;
  logic [COORD_W-1:0] pix_x_q, pix_x_d;
  logic [COORD_W-1:0] pix_y_q, pix_y_d;
  logic [15:0]        frame_q, frame_d;
  logic [7:0]         uo_q, uo_d;

  logic        wr_en, wr_ctrl, wr_color, wr_frame;
  logic [31:0] wmask;
  logic        en_cur, en_nxt, advance, x_wrap, y_wrap;
  logic        hs_raw, vs_raw, visible, sync_inv, bit_x, bit_y;
  logic [5:0]  fg, bg, pixel;
  logic [31:0] irq_line_rd;
  logic        pending_rd;

  always_comb begin
    wr_en    = data_write_n != 2'b11;
    wmask    = {{16{data_write_n == 2'b10}},
                {8{(data_write_n == 2'b01) || (data_write_n == 2'b10)}},
                {8{wr_en}}};
    wr_ctrl  = wr_en && (address == 6'h00);
    wr_color = wr_en && (address == 6'h04);
    wr_frame = wr_en && (address == 6'h10);
  end

  always_comb begin
    ctrl_d = ctrl_q;
    if (wr_ctrl) ctrl_d = data_in[6:0];

    color_d = color_q;
    if (wr_color) begin
      color_d[5:0] = data_in[5:0];
      if (wmask[8]) color_d[11:6] = data_in[13:8];
    end
  end

  // Disabling zeroes the counters on the write edge; enabling holds them at
  // (0,0) for that edge so the first counted pixel is the origin.
  always_comb begin
    en_cur  = ctrl_q[0];
    en_nxt  = ctrl_d[0];
    advance = en_cur && en_nxt;
    x_wrap  = pix_x_q == X_LAST;
    y_wrap  = pix_y_q == Y_LAST;
    pix_x_d = pix_x_q;
    pix_y_d = pix_y_q;
    if (!en_nxt) begin
      pix_x_d = '0;
      pix_y_d = '0;
    end else if (en_cur) begin
      pix_x_d = x_wrap ? '0 : pix_x_q + COORD_W'(1);
      if (x_wrap) pix_y_d = y_wrap ? '0 : pix_y_q + COORD_W'(1);
    end

    frame_d = frame_q;
    if (advance && x_wrap && y_wrap) frame_d = frame_q + 16'd1;
    if (wr_frame) frame_d = 16'd0;
  end

  always_comb begin
    fg       = color_q[5:0];
    bg       = color_q[11:6];
    sync_inv = ~ctrl_q[1];
    hs_raw   = en_cur && (pix_x_q >= HS_START) && (pix_x_q < HS_END);
    vs_raw   = en_cur && (pix_y_q >= VS_START) && (pix_y_q < VS_END);
    visible  = en_cur && (pix_x_q < X_VIS) && (pix_y_q < Y_VIS);
    bit_x    = |(pix_x_q & (COORD_W'(1) << ctrl_q[6:4]));
    bit_y    = |(pix_y_q & (COORD_W'(1) << ctrl_q[6:4]));
    case (ctrl_q[3:2])
      2'd0:    pixel = fg;
      2'd1:    pixel = (bit_x ^ bit_y) ? fg : bg;
      2'd2:    pixel = bit_x ? fg : bg;
      default: pixel = bg;
    endcase
    if (!visible) pixel = 6'd0;
    uo_d = {vs_raw ^ sync_inv, hs_raw ^ sync_inv, pixel};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q  <= '0;
      color_q <= '0;
      pix_x_q <= '0;
      pix_y_q <= '0;
      frame_q <= '0;
      uo_q    <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      color_q <= color_d;
      pix_x_q <= pix_x_d;
      pix_y_q <= pix_y_d;
      frame_q <= frame_d;
      uo_q    <= uo_d;
    end
  end

`ifdef VGA_RASTER_IRQ_EN
  logic [COORD_W-1:0] irq_line_q, irq_line_d;
  logic               pending_q, pending_d;
  logic               wr_irql, wr_irq, irq_hit;

  // A line number beyond the frame never matches because pix_y_d < V_TOTAL.
  always_comb begin
    wr_irql = wr_en && (address == 6'h08);
    wr_irq  = wr_en && (address == 6'h14);
    irq_line_d = irq_line_q;
    if (wr_irql)
      irq_line_d = (irq_line_q & ~wmask[COORD_W-1:0]) | (data_in[COORD_W-1:0] & wmask[COORD_W-1:0]);
    irq_hit   = advance && (pix_x_d == '0) && (pix_y_d == irq_line_q);
    pending_d = pending_q;
    if (wr_irq && data_in[0]) pending_d = 1'b0;
    if (irq_hit) pending_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_line_q <= '0;
      pending_q  <= 1'b0;
    end else begin
      irq_line_q <= irq_line_d;
      pending_q  <= pending_d;
    end
  end

  assign user_interrupt = pending_q;
  assign irq_line_rd    = 32'(irq_line_q);
  assign pending_rd     = pending_q;
`else
  assign user_interrupt = 1'b0;
  assign irq_line_rd    = 32'd0;
  assign pending_rd     = 1'b0;
`endif

  always_comb begin
    data_out = 32'd0;
    case (address)
      6'h00:   data_out = {25'd0, ctrl_q};
      6'h04:   data_out = {18'd0, color_q[11:6], 2'b00, color_q[5:0]};
      6'h08:   data_out = irq_line_rd;
      6'h0C:   data_out = {16'(pix_y_q), 16'(pix_x_q)};
      6'h10:   data_out = {16'd0, frame_q};
      6'h14:   data_out = {31'd0, pending_rd};
      default: data_out = 32'd0;
    endcase
  end

  assign uo_out     = uo_q;
  assign data_ready = 1'b1;

  logic unused_ok;
  assign unused_ok = &{1'b0, ui_in, data_read_n, data_in, wmask};

endmodule

`default_nettype wire

// File: tb/tb_tqvp_vga_raster.sv
// ============================================================================
// Module   : tb_tqvp_vga_raster
// Brief    : Self-checking bench for tqvp_vga_raster (small 12x7 raster).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_tqvp_vga_raster;

  localparam int HA = 8, HF = 1, HS = 2, HB = 1;
  localparam int VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
`ifdef VGA_RASTER_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  ui_in;
  logic [7:0]  uo_out;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] data_out;
  logic        data_ready;
  logic        user_interrupt;

  always #5 clk = ~clk;

  tqvp_vga_raster #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .COORD_W(10)
  ) dut (
    .clk(clk), .reset(reset), .ui_in(ui_in), .uo_out(uo_out),
    .address(address), .data_in(data_in), .data_write_n(data_write_n),
    .data_read_n(data_read_n), .data_out(data_out), .data_ready(data_ready),
    .user_interrupt(user_interrupt)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state (pre-edge values between ticks)
  logic [6:0]  m_ctrl;
  logic [5:0]  m_fg, m_bg;
  logic [9:0]  m_irql;
  logic [15:0] m_frame;
  logic        m_pend;
  logic [9:0]  mx, my;
  logic [7:0]  exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_uo(input logic [9:0] x, input logic [9:0] y,
                                        input logic [6:0] c, input logic [5:0] fg,
                                        input logic [5:0] bg);
    logic en, pol, hs, vs, vis;
    logic [2:0] sh;
    logic [5:0] col;
    en  = c[0];
    pol = c[1];
    sh  = c[6:4];
    hs  = en && (x >= HA + HF) && (x < HA + HF + HS);
    vs  = en && (y >= VA + VF) && (y < VA + VF + VS);
    vis = en && (x < HA) && (y < VA);
    case (c[3:2])
      2'd0:    col = fg;
      2'd1:    col = (x[sh] ^ y[sh]) ? fg : bg;
      2'd2:    col = x[sh] ? fg : bg;
      default: col = bg;
    endcase
    if (!vis) col = 6'd0;
    return {vs ^ !pol, hs ^ !pol, col};
  endfunction

  // One clock: drive optional write, predict, advance model, compare.
  task automatic tick(input logic wr, input logic [5:0] a, input logic [31:0] d, input logic [1:0] wn);
    logic en_cur, en_nxt, adv, l1, set;
    logic [9:0] nx, ny;
    @(negedge clk);
    if (wr) begin
      address = a; data_in = d; data_write_n = wn;
    end
    exp_q.push_back(exp_uo(mx, my, m_ctrl, m_fg, m_bg));
    l1     = wr && (wn == 2'b01 || wn == 2'b10);
    en_cur = m_ctrl[0];
    en_nxt = (wr && a == 6'h00) ? d[0] : m_ctrl[0];
    adv = 1'b0; nx = mx; ny = my;
    if (!en_nxt) begin
      nx = 10'd0; ny = 10'd0;
    end else if (en_cur) begin
      adv = 1'b1;
      if (mx == HT - 1) begin
        nx = 10'd0;
        ny = (my == VT - 1) ? 10'd0 : my + 10'd1;
      end else nx = mx + 10'd1;
    end
    set = IRQ_ON && adv && nx == 10'd0 && ny == m_irql;
    if (adv && mx == HT - 1 && my == VT - 1) m_frame = m_frame + 16'd1;
    if (wr && a == 6'h10) m_frame = 16'd0;
    if (wr && a == 6'h14 && d[0]) m_pend = 1'b0;
    if (set) m_pend = 1'b1;
    if (wr && a == 6'h00) m_ctrl = d[6:0];
    if (wr && a == 6'h04) begin
      m_fg = d[5:0];
      if (l1) m_bg = d[13:8];
    end
    if (IRQ_ON && wr && a == 6'h08) begin
      m_irql[7:0] = d[7:0];
      if (l1) m_irql[9:8] = d[9:8];
    end
    mx = nx; my = ny;
    @(posedge clk); #1;
    check("uo_out", {24'd0, uo_out}, {24'd0, exp_q.pop_front()});
    check("user_interrupt", {31'd0, user_interrupt}, {31'd0, m_pend});
    if (!wr) check("pos", data_out, {6'd0, my, 6'd0, mx});
    data_write_n = 2'b11; address = 6'h0C; data_in = 32'd0;
  endtask

  task automatic idle();
    tick(1'b0, 6'h0C, 32'd0, 2'b11);
  endtask

  task automatic rd_check(input string tag, input logic [5:0] a, input logic [31:0] exp);
    address = a;
    #1;
    check(tag, data_out, exp);
    address = 6'h0C;
  endtask

  task automatic run_to(input logic [9:0] x, input logic [9:0] y);
    int n = 0;
    while (!(mx == x && my == y) && n < 300) begin
      idle();
      n++;
    end
    check("run_to_bound", {31'd0, (mx == x && my == y)}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; ui_in = 8'd0; address = 6'h0C; data_in = 32'd0;
    data_write_n = 2'b11; data_read_n = 2'b11;
    m_ctrl = '0; m_fg = '0; m_bg = '0; m_irql = '0; m_frame = '0; m_pend = 1'b0;
    mx = '0; my = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_uo", {24'd0, uo_out}, 32'd0);
    check("rst_irq", {31'd0, user_interrupt}, 32'd0);
    check("data_ready", {31'd0, data_ready}, 32'd1);
    rd_check("rst_ctrl", 6'h00, 32'd0);
    rd_check("rst_color", 6'h04, 32'd0);
    rd_check("rst_pos", 6'h0C, 32'd0);
    rd_check("rst_frame", 6'h10, 32'd0);
    reset = 1'b0;

    // First edge after reset applies POL=0: inactive-high syncs
    idle();
    check("uo_after_rst", {24'd0, uo_out}, 32'h0000_00C0);
    tick(1'b1, 6'h00, 32'hFFFF_FF80, 2'b10);
    rd_check("ctrl_unused_bits", 6'h00, 32'd0);
    rd_check("unmapped", 6'h3C, 32'd0);

    tick(1'b1, 6'h00, 32'h0000_0003, 2'b00);
    rd_check("ctrl_03", 6'h00, 32'h3);
    repeat (14) idle();
    for (int i = 8; i <= 11; i++) begin
      run_to(10'(i), 10'd0);
      idle();
      check("hsync", {31'd0, uo_out[6]}, {31'd0, (i == 9 || i == 10)});
    end

    run_to(10'd0, 10'd0);
    tick(1'b1, 6'h10, 32'd0, 2'b00);
    repeat (3 * HT * VT) idle();
    rd_check("frame_3", 6'h10, 32'd3);
    run_to(10'(HT - 1), 10'(VT - 1));
    tick(1'b1, 6'h10, 32'hFFFF_FFFF, 2'b00);
    rd_check("frame_clr_on_wrap", 6'h10, 32'd0);

    tick(1'b1, 6'h08, 32'h0000_0002, 2'b00);
    rd_check("irq_line", 6'h08, IRQ_ON ? 32'd2 : 32'd0);
    tick(1'b1, 6'h14, 32'h1, 2'b00);
    run_to(10'(HT - 1), 10'd1);
    check("irq_low", {31'd0, user_interrupt}, 32'd0);
    idle();
    check("irq_rise", {31'd0, user_interrupt}, {31'd0, IRQ_ON});
    rd_check("irq_reg", 6'h14, {31'd0, IRQ_ON});
    tick(1'b1, 6'h14, 32'h1, 2'b00);
    check("irq_cleared", {31'd0, user_interrupt}, 32'd0);
    run_to(10'(HT - 1), 10'd1);
    tick(1'b1, 6'h14, 32'h1, 2'b00);
    check("irq_set_wins", {31'd0, user_interrupt}, {31'd0, IRQ_ON});
    tick(1'b1, 6'h14, 32'h1, 2'b00);

    tick(1'b1, 6'h04, 32'h0000_0330, 2'b10);
    tick(1'b1, 6'h00, 32'h0000_0015, 2'b00);
    rd_check("color", 6'h04, 32'h0330);
    run_to(10'd2, 10'd0); idle();
    check("px_2_0_fg", {24'd0, uo_out}, 32'hF0);
    run_to(10'd2, 10'd2); idle();
    check("px_2_2_bg", {24'd0, uo_out}, 32'hC3);
    run_to(10'd8, 10'd0); idle();
    check("px_8_0_blank", {24'd0, uo_out}, 32'hC0);

    tick(1'b1, 6'h04, 32'h0000_2A15, 2'b00);
    rd_check("color_lane8", 6'h04, 32'h0315);
    tick(1'b1, 6'h04, 32'hFFFF_3F00, 2'b01);
    rd_check("color_lane16", 6'h04, 32'h3F00);
    tick(1'b1, 6'h04, 32'h0000_2A15, 2'b10);
    tick(1'b1, 6'h00, 32'h0000_0029, 2'b00);
    repeat (HT * VT) idle();
    tick(1'b1, 6'h00, 32'h0000_000F, 2'b00);
    repeat (HT * VT) idle();

    tick(1'b1, 6'h00, 32'h0000_0003, 2'b00);
    run_to(10'd5, 10'd1);
    tick(1'b1, 6'h00, 32'h0000_0002, 2'b00);
    rd_check("pos_after_disable", 6'h0C, 32'd0);
    idle();
    check("pol1_idle_sync", {30'd0, uo_out[7:6]}, 32'd0);
    tick(1'b1, 6'h00, 32'h0000_0003, 2'b00);
    rd_check("pos_reenable", 6'h0C, 32'd0);
    idle();
    rd_check("pos_reenable_next", 6'h0C, 32'h0000_0001);

    repeat (20) idle();
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_uo", {24'd0, uo_out}, 32'd0);
    check("async_rst_irq", {31'd0, user_interrupt}, 32'd0);
    rd_check("async_rst_ctrl", 6'h00, 32'd0);
    rd_check("async_rst_color", 6'h04, 32'd0);
    rd_check("async_rst_irql", 6'h08, 32'd0);
    rd_check("async_rst_pos", 6'h0C, 32'd0);
    rd_check("async_rst_frame", 6'h10, 32'd0);
    rd_check("async_rst_pend", 6'h14, 32'd0);
    exp_q.delete();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
